// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared FSM encoding, reset vector default and word alignment.
package fetch_sequencer_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_ERR = 2'd3;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [1:0] WORD_ALIGN = 2'b00;
endpackage

// File: rtl/fetch_sequencer_next_pc.sv
// next_pc_select: jump > taken branch > sequential next-PC selection.
module next_pc_select
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_en_i,
  input  logic [25:0]       jump_addr_i,
  input  logic              branch_en_i,
  input  logic              zero_flag_i,
  input  logic [ADDR_W-1:0] branch_offset_i,
  output logic [ADDR_W-1:0] next_pc_o
);
  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] off;
  always_comb begin
    pc4 = pc_i + ADDR_W'(4);
    off = branch_offset_i & ~ADDR_W'(3);
    next_pc_o = jump_en_i ? {pc4[ADDR_W-1:28], jump_addr_i, WORD_ALIGN}
              : (branch_en_i && zero_flag_i) ? pc4 + off
              : pc4;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner sequencing imem req/ack fetches and holding the instruction for decode.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter int                MAX_WAIT     = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              stall_i,
  input  logic              jump_en_i,
  input  logic [25:0]       jump_addr_i,
  input  logic              branch_en_i,
  input  logic              zero_flag_i,
  input  logic [ADDR_W-1:0] branch_offset_i,
  output logic              fetch_err_o
);
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, ipc_q, ipc_d, next_pc;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d, err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  next_pc_select #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc_i            (pc_q),
    .jump_en_i       (jump_en_i),
    .jump_addr_i     (jump_addr_i),
    .branch_en_i     (branch_en_i),
    .zero_flag_i     (zero_flag_i),
    .branch_offset_i (branch_offset_i),
    .next_pc_o       (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ipc_d = ipc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d = err_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          ipc_d = pc_q;
          valid_d = 1'b1;
          cnt_d = 8'd0;
          state_d = S_HOLD;
        end else if (cnt_q == LAST_WAIT) begin
          err_d = 1'b1;
          state_d = S_ERR;
        end
      end
      S_HOLD: begin
        if (!stall_i) begin
          pc_d = next_pc;
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pc_q <= RESET_VECTOR;
      ipc_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ipc_q <= ipc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign imem_req_o = (state_q == S_REQ);
  assign imem_addr_o = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o = instr_q;
  assign instr_pc_o = ipc_q;
  assign fetch_err_o = err_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench; stimulus queues expected fetch addresses/instructions, a monitor checks them.
module tb_fetch_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, ack = 1'b0, stall = 1'b1;
  logic        jen = 1'b0, ben = 1'b0, zf = 1'b0;
  logic [31:0] rdata = '0, boff = '0;
  logic [25:0] jaddr = '0;
  logic        imem_req, instr_valid, fetch_err;
  logic [31:0] imem_addr, instr, instr_pc;
  logic [31:0] last_data, last_addr;
  logic [31:0] exp_addr[$];
  logic [63:0] exp_ins[$];
  int          n_cmp = 0, n_err = 0;
  logic        prev_req = 1'b0, prev_val = 1'b0;

  fetch_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(ack), .imem_rdata_i(rdata), .instr_valid_o(instr_valid), .instr_o(instr),
    .instr_pc_o(instr_pc), .stall_i(stall), .jump_en_i(jen), .jump_addr_i(jaddr),
    .branch_en_i(ben), .zero_flag_i(zf), .branch_offset_i(boff), .fetch_err_o(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (imem_req && !prev_req) begin
      if (exp_addr.size() == 0) chk("unexpected_req", {1'b1, imem_addr}, 0);
      else chk("req_addr", imem_addr, exp_addr.pop_front());
    end
    if (instr_valid && !prev_val) begin
      if (exp_ins.size() == 0) chk("unexpected_instr", {1'b1, instr, instr_pc}, 0);
      else chk("instr_word_pc", {instr, instr_pc}, exp_ins.pop_front());
    end
    prev_req = imem_req;
    prev_val = instr_valid;
  end

  task automatic wait_req();
    for (int i = 0; i < 40 && !imem_req; i++) @(negedge clk);
    chk("req_wait_bound", imem_req, 1'b1);
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input int dly);
    exp_ins.push_back({d, a});
    last_data = d;
    last_addr = a;
    wait_req();
    repeat (dly) @(negedge clk);
    ack = 1'b1;
    rdata = d;
    @(negedge clk);
    ack = 1'b0;
    chk("in_hold", {instr_valid, imem_req}, 2'b10);
  endtask

  task automatic consume(input int ns, input logic je, input logic [25:0] ja, input logic be,
                         input logic z, input logic [31:0] off, input logic [31:0] nxt);
    exp_addr.push_back(nxt);
    for (int i = 0; i < ns; i++) begin
      ack = (i == 0);
      rdata = 32'hDEAD_BEEF;
      jen = 1'b1;
      jaddr = 26'h3FF_FFFF;
      @(negedge clk);
      chk("stall_hold", {instr_valid, imem_req, instr, instr_pc}, {2'b10, last_data, last_addr});
    end
    ack = 1'b0;
    stall = 1'b0;
    jen = je; jaddr = ja; ben = be; zf = z; boff = off;
    @(negedge clk);
    stall = 1'b1;
    jen = 1'b0; ben = 1'b0; zf = 1'b0;
    chk("consumed", {instr_valid, imem_req}, 2'b01);
  endtask

  initial begin
    #1;
    chk("reset_outs", {imem_req, instr_valid, fetch_err, imem_addr, instr, instr_pc}, 0);
    repeat (2) @(negedge clk);
    exp_addr.push_back(32'h0);
    rst_n = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("idle_ack_ignored", {instr_valid, imem_req}, 2'b01);
    do_fetch(32'h0, 32'h2008_0005, 0);
    consume(0, 0, 0, 0, 0, 0, 32'h4);
    do_fetch(32'h4, 32'hAAAA_0001, 2);
    consume(3, 0, 0, 0, 0, 0, 32'h8);
    do_fetch(32'h8, 32'h8C01_0000, 1);
    consume(0, 1, 26'h010_0004, 0, 0, 0, 32'h0040_0010);
    do_fetch(32'h0040_0010, 32'h0800_0000, 0);
    consume(0, 1, 26'h010_0000, 1, 1, 32'h40, 32'h0040_0000);
    do_fetch(32'h0040_0000, 32'h1111_2222, 0);
    consume(0, 1, 26'h40, 0, 0, 0, 32'h100);
    do_fetch(32'h100, 32'h1000_FFFE, 0);
    consume(0, 0, 0, 1, 1, 32'hFFFF_FFF8, 32'hFC);
    do_fetch(32'hFC, 32'h3333_4444, 0);
    consume(0, 1, 26'h40, 0, 0, 0, 32'h100);
    do_fetch(32'h100, 32'h1000_FFFE, 0);
    consume(0, 0, 0, 1, 0, 32'hFFFF_FFF8, 32'h104);
    do_fetch(32'h104, 32'h5555_6666, 0);
    consume(0, 0, 0, 1, 1, 32'hFFFF_FEF4, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC, 32'h7777_8888, 0);
    consume(0, 0, 0, 0, 0, 0, 32'h0);
    do_fetch(32'h0, 32'h9999_AAAA, 0);
    consume(0, 0, 0, 0, 0, 0, 32'h4);
    wait_req();
    repeat (14) @(negedge clk);
    chk("pre_timeout", {fetch_err, imem_req}, 2'b01);
    @(negedge clk);
    chk("timeout_err", {fetch_err, imem_req, instr_valid}, 3'b100);
    ack = 1'b1;
    rdata = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    ack = 1'b0;
    chk("err_sticky", {fetch_err, imem_req, instr_valid}, 3'b100);
    #2 rst_n = 1'b0;
    #1 chk("err_reset_async", {fetch_err, imem_req, imem_addr}, 0);
    @(negedge clk);
    exp_addr.push_back(32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    do_fetch(32'h0, 32'hABCD_0123, 0);
    consume(0, 0, 0, 0, 0, 0, 32'h4);
    do_fetch(32'h4, 32'h0800_0008, 0);
    consume(0, 1, 26'h8, 0, 0, 0, 32'h20);
    wait_req();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midreq_reset_async",
           {imem_req, instr_valid, fetch_err, imem_addr, instr, instr_pc}, 0);
    @(negedge clk);
    exp_addr.push_back(32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    do_fetch(32'h0, 32'h1234_5678, 0);
    consume(0, 0, 0, 0, 0, 0, 32'h4);
    repeat (2) @(negedge clk);
    chk("queues_drained", {exp_addr.size(), exp_ins.size()}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle instruction fetch controller. It owns the program counter register and sequences each fetch through a request/acknowledge handshake with instruction memory. It holds the fetched instruction for decode until the decode stage releases its stall, then selects the next PC from jump, taken-branch or sequential. It sits between instruction memory and the decode/branch-resolution logic.

Parameters:
ADDR_W, 32, PC and memory address width (bits [1:0] always 00)
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
MAX_WAIT, 15, REQ-state cycles without imem_ack before fetch error (1..255)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
imem_req  output  1  fetch request, high throughout REQ state
imem_addr  output  ADDR_W  fetch address, equals pc
imem_ack  input  1  memory acknowledges; imem_rdata valid this cycle
imem_rdata  input  32  instruction word from memory
instr_valid  output  1  instr/instr_pc hold a fetched instruction
instr  output  32  held instruction word
instr_pc  output  ADDR_W  address of held instruction
stall  input  1  decode not ready; keep holding instruction
jump_en  input  1  held instruction is a jump
jump_addr  input  26  jump target field
branch_en  input  1  held instruction is a branch
zero_flag  input  1  branch condition true
branch_offset  input  ADDR_W  sign-extended, word-shifted branch offset
fetch_err  output  1  sticky memory-timeout flag

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, pc=RESET_VECTOR, instr=0, instr_pc=0, instr_valid=0, imem_req=0, fetch_err=0, wait counter=0. An in-flight request is abandoned, and a later imem_ack for it is not observed because the state is no longer REQ.
- States: IDLE, REQ, HOLD, ERR.
- IDLE: lasts one cycle after reset deassertion, then moves to REQ.
- REQ: imem_req=1, imem_addr=pc, and the wait counter increments each cycle.
  - If imem_ack=1: capture instr<=imem_rdata and instr_pc<=pc, set instr_valid<=1, clear the counter, go to HOLD.
  - Else if counter==MAX_WAIT-1: go to ERR and set fetch_err<=1.
- HOLD: imem_req=0, and instr_valid, instr and instr_pc are held stable.
  - If stall=1: remain in HOLD.
  - If stall=0: the instruction is consumed this cycle. Set pc<=next_pc and instr_valid<=0, and go to REQ.
- ERR: imem_req=0, instr_valid=0, fetch_err=1. The only exit is reset.
- next_pc, evaluated only in the HOLD cycle where stall=0, with pc4 = pc + 4 (modulo 2^ADDR_W):
  - jump_en=1: {pc4[31:28], jump_addr, 2'b00}. Jump has priority over branch.
  - else branch_en & zero_flag: pc4 + {branch_offset[31:2], 2'b00}
  - else: pc4
- Jump, branch and zero inputs are ignored in every cycle except the consuming HOLD cycle.
- imem_ack outside REQ is spurious: ignore it, with no state change.
- Latency: an acknowledgement in cycle N gives instr_valid=1 in cycle N+1. With stall=0 in cycle N+1, the next request is issued in cycle N+2. Best-case throughput is one instruction per 2 cycles.
- Wrap-around: pc=32'hFFFF_FFFC sequential gives 0. Branch addition wraps modulo 2^32 with no overflow flag.
- Address alignment: imem_addr[1:0] is always 2'b00.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, REQ, HOLD, ERR, 2 bits)
  - default RESET_VECTOR
  - the word-alignment constant
- One natural combinational sub-module, next_pc_select. Inputs: pc, jump_en, jump_addr, branch_en, zero_flag, branch_offset. Output: next_pc. It is reusable by a later pipelined fetch stage.

Test Plan:
- Reset then ack on the first REQ cycle with rdata=32'h2008_0005 -> imem_addr=0; next cycle instr_valid=1, instr=32'h2008_0005, instr_pc=0. With stall=0, the next imem_addr=4.
- Hold stall=1 for 3 cycles in HOLD -> instr_valid stays 1 with instr unchanged and imem_req=0. Release stall -> REQ at pc+4 the cycle after.
- At pc=32'h0040_0010, assert jump_en=1 and branch_en=zero_flag=1 with jump_addr=26'h010_0000 -> next imem_addr=32'h0040_0000, showing jump wins over branch.
- At pc=32'h100, branch_en=1 with branch_offset=-8: zero_flag=1 -> next addr 32'hFC; zero_flag=0 -> next addr 32'h104.
- Withhold imem_ack for MAX_WAIT cycles -> fetch_err=1 and state ERR. A later ack is ignored, and reset pulse clears fetch_err and restarts at RESET_VECTOR.
- Assert reset mid-REQ at pc=32'h20 -> all outputs 0 immediately, without waiting for a clock edge, and fetch resumes at RESET_VECTOR. A spurious ack in IDLE/HOLD causes no change.
